// File: rtl/chart_access_arbiter.sv
// chart_access_arbiter: three-requester arbiter serialising read/write/reject accesses to a chart store.
// Ports: clk, sys_rst (sync, active-high); req/we per requester; id (byte) and wdata (chart) per requester;
//        done (one-hot pulse), err (id-0 reject), rdata (last read chart), busy;
//        st_read_id/st_write_id/st_wdata drive the store, st_rdata is its registered read output.
// Build option: define CHART_ARB_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module chart_access_arbiter #(
  parameter int CW = 32
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [2:0][7:0]     id,
  input  logic [2:0][CW-1:0]  wdata,
  output logic [2:0]          done,
  output logic                err,
  output logic [CW-1:0]       rdata,
  output logic                busy,
  output logic [7:0]          st_read_id,
  output logic [7:0]          st_write_id,
  output logic [CW-1:0]       st_wdata,
  input  logic [CW-1:0]       st_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [1:0] gnt, win;
  logic gnt_v, take, sel_we, op_we, rej;
  logic [7:0] sel_id;
  logic [CW-1:0] sel_wdata;
`ifdef CHART_ARB_RR_EN
  logic [1:0] ptr;
  always_comb begin
    gnt = ptr == 2'd0 ? (req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2) :
          ptr == 2'd1 ? (req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd0) :
                        (req[2] ? 2'd2 : req[0] ? 2'd0 : 2'd1);
  end
  always_ff @(posedge clk) begin
    if (sys_rst) ptr <= 2'd0;
    else if (take) ptr <= gnt == 2'd2 ? 2'd0 : gnt + 2'd1;
  end
`else
  always_comb begin
    gnt = req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2;
  end
`endif
  assign gnt_v     = |req;
  assign take      = state == IDLE && gnt_v;
  assign sel_we    = gnt == 2'd0 ? we[0] : gnt == 2'd1 ? we[1] : we[2];
  assign sel_id    = gnt == 2'd0 ? id[0] : gnt == 2'd1 ? id[1] : id[2];
  assign sel_wdata = gnt == 2'd0 ? wdata[0] : gnt == 2'd1 ? wdata[1] : wdata[2];
  always_ff @(posedge clk) begin
    if (sys_rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 3'b000;
    err  = 1'b0;
    nxt  = state == IDLE  ? (gnt_v ? (sel_id == 8'd0 ? RESP : ISSUE) : IDLE) :
           state == ISSUE ? (op_we ? RESP : WAIT) :
           state == WAIT  ? RESP : IDLE;
    busy = state != IDLE;
    done = state == RESP ? 3'b001 << win : 3'b000;
    err  = state == RESP && rej;
  end
  // Store drives are loaded only on the IDLE grant and cleared on every other
  // edge, so they are non-zero exactly during the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      st_read_id  <= '0;
      st_write_id <= '0;
      st_wdata    <= '0;
      rdata       <= '0;
      win         <= '0;
      op_we       <= 1'b0;
      rej         <= 1'b0;
    end else begin
      st_read_id  <= take && !sel_we ? sel_id : 8'd0;
      st_write_id <= take && sel_we ? sel_id : 8'd0;
      st_wdata    <= take && sel_we && sel_id != 8'd0 ? sel_wdata : '0;
      if (take) begin
        win   <= gnt;
        op_we <= sel_we;
        rej   <= sel_id == 8'd0;
      end
      if (state == WAIT) rdata <= st_rdata;
    end
  end
endmodule

// File: tb/tb_chart_access_arbiter.sv
// tb_chart_access_arbiter: randomized scoreboard bench for chart_access_arbiter with a behavioural chart store.
module tb_chart_access_arbiter;
  localparam int CW = 32;
  logic clk = 1'b0;
  logic sys_rst;
  logic [2:0] req, we, done;
  logic [2:0][7:0] id;
  logic [2:0][CW-1:0] wdata;
  logic err, busy;
  logic [CW-1:0] rdata, st_wdata, st_rdata;
  logic [7:0] st_read_id, st_write_id;
  logic wipe;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  chart_access_arbiter #(.CW(CW)) dut (
    .clk(clk), .sys_rst(sys_rst), .req(req), .we(we), .id(id), .wdata(wdata),
    .done(done), .err(err), .rdata(rdata), .busy(busy),
    .st_read_id(st_read_id), .st_write_id(st_write_id), .st_wdata(st_wdata), .st_rdata(st_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CW-1:0] smem [256];
  always @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < 256; i++) smem[i] <= '0;
      st_rdata <= '0;
    end else begin
      st_rdata <= smem[st_read_id];
      if (st_write_id != 8'd0) smem[st_write_id] <= st_wdata;
    end
  end

  typedef struct {
    logic [2:0]    dn;
    logic          e;
    logic [CW-1:0] rd;
    logic          w;
    logic [7:0]    i;
    logic [CW-1:0] wd;
    int            c0;
    int            lat;
  } exp_t;
  exp_t q[$];

  int ptr = 0;
  logic [CW-1:0] ref_mem [256];
  logic [CW-1:0] last_rd = '0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, x, cyc);
    end
  endtask

  function automatic int pick(logic [2:0] r);
`ifdef CHART_ARB_RR_EN
    for (int k = 0; k < 3; k++) if (r[(ptr + k) % 3]) return (ptr + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (r[k]) return k;
`endif
    return 0;
  endfunction

  task automatic all_zero(string n);
    chk({n, "_done"}, 64'(done), 0);
    chk({n, "_err"}, 64'(err), 0);
    chk({n, "_busy"}, 64'(busy), 0);
    chk({n, "_st_rid"}, 64'(st_read_id), 0);
    chk({n, "_st_wid"}, 64'(st_write_id), 0);
    chk({n, "_st_wdata"}, 64'(st_wdata), 0);
    chk({n, "_rdata"}, 64'(rdata), 0);
  endtask

  // mode: 0 normal, 1 drop req[winner] during ISSUE, 2 reset during WAIT
  task automatic issue(logic [2:0] r, logic [2:0] w, logic [2:0][7:0] ids, logic [2:0][CW-1:0] wd, int mode);
    int g, t;
    exp_t e;
    req = r; we = w; id = ids; wdata = wd;
    g = pick(r);
    ptr = (g + 1) % 3;
    e.dn = 3'(1 << g);
    e.e = ids[g] == 8'd0;
    e.w = w[g];
    e.i = ids[g];
    e.wd = wd[g];
    e.c0 = cyc;
    if (e.e) e.lat = 1;
    else if (e.w) begin
      ref_mem[e.i] = e.wd;
      e.lat = 2;
    end else begin
      last_rd = ref_mem[e.i];
      e.lat = 3;
    end
    e.rd = last_rd;
    q.push_back(e);
    if (mode == 2) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      sys_rst = 1'b1;
      @(posedge clk); #1;
      sys_rst = 1'b0;
      req = '0;
      q.delete();
      ptr = 0;
      last_rd = '0;
      all_zero("rst_mid");
      return;
    end
    if (mode == 1) begin
      @(posedge clk); #1;
      req[g] = 1'b0;
    end
    for (t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done != 3'b000) break;
    end
    if (t == 12) begin
      chk("done_timeout", 64'(done), 64'(e.dn));
      q.delete();
    end
    @(posedge clk); #1;
    req = '0;
  endtask

  always @(negedge clk) begin
    if (!sys_rst && !wipe) begin
      if (st_read_id != 8'd0 || st_write_id != 8'd0) begin
        chk("st_excl", 64'(st_read_id != 8'd0 && st_write_id != 8'd0), 0);
        if (q.size() == 0) chk("st_unexpected", 64'(st_read_id | st_write_id), 0);
        else begin
          chk("st_rid", 64'(st_read_id), q[0].w ? 0 : 64'(q[0].i));
          chk("st_wid", 64'(st_write_id), q[0].w ? 64'(q[0].i) : 0);
          chk("st_cyc", 64'(cyc), 64'(q[0].c0 + 1));
          if (q[0].w) chk("st_wdata", 64'(st_wdata), 64'(q[0].wd));
        end
      end else if (busy) chk("st_wdata_idle", 64'(st_wdata), 0);
      if (done != 3'b000) begin
        if (q.size() == 0) chk("done_unexpected", 64'(done), 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done", 64'(done), 64'(e.dn));
          chk("err", 64'(err), 64'(e.e));
          chk("rdata", 64'(rdata), 64'(e.rd));
          chk("latency", 64'(cyc - e.c0), 64'(e.lat));
          chk("busy_resp", 64'(busy), 1);
        end
      end
    end
  end

  initial begin
    logic [2:0][7:0] ids;
    logic [2:0][CW-1:0] wd;
    sys_rst = 1'b1; wipe = 1'b1;
    req = '0; we = '0; id = '0; wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    sys_rst = 1'b0; wipe = 1'b0;
    @(posedge clk); #1;
    ids = {8'd0, 8'd3, 8'd0};
    wd = {32'h0, 32'hCAFE_0003, 32'h0};
    issue(3'b010, 3'b010, ids, wd, 0);
    ids = {8'd0, 8'd0, 8'd3};
    issue(3'b001, 3'b000, ids, '0, 0);
    ids = {8'd0, 8'd0, 8'd2};
    issue(3'b001, 3'b000, ids, '0, 0);
    ids = {8'd0, 8'd5, 8'd5};
    issue(3'b100, 3'b000, ids, '0, 0);
    ids = {8'd4, 8'd1, 8'd3};
    wd = {32'hA4, 32'hB1, 32'hC3};
    for (int k = 0; k < 4; k++) issue(3'b111, 3'b000, ids, wd, 0);
    issue(3'b001, 3'b000, ids, wd, 1);
    issue(3'b001, 3'b000, ids, wd, 2);
    issue(3'b010, 3'b000, ids, wd, 0);
    for (int k = 0; k < 80; k++) begin
      for (int j = 0; j < 3; j++) begin
        ids[j] = 8'($urandom_range(0, 6));
        wd[j] = $urandom;
      end
      issue(3'($urandom_range(1, 7)), 3'($urandom), ids, wd, $urandom_range(0, 4) == 0 ? 1 : 0);
    end
    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chart_access_arbiter.md
CHART_ACCESS_ARBITER -- requirements
Module: chart_access_arbiter

Interface
REQ-001 The block SHALL have these ports: clk  in  1  system clock.
REQ-002 sys_rst  in  1  synchronous, active-high reset; one clock domain (clk) only.
REQ-003 req  in  3  per-requester access request; bit i belongs to requester i; held high until done[i].
REQ-004 we  in  3  per-requester operation: 1 = write chart, 0 = read chart; stable while req[i] is high.
REQ-005 id  in  3 x byte  per-requester chart id; 0 is invalid.
REQ-006 wdata  in  3 x Chart  per-requester chart to write; stable while req[i] is high.
REQ-007 done  out  3  one-cycle completion pulse to the granted requester.
REQ-008 err  out  1  valid with any done bit; 1 = request rejected because id was 0.
REQ-009 rdata  out  Chart  read result; valid while done is non-zero and held until the next read completes.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 st_read_id, st_write_id  out  byte each  registered drive of the chart storage read and write id inputs.
REQ-012 st_wdata  out  Chart  registered drive of the chart storage write-data input.
REQ-013 st_rdata  in  Chart  chart storage registered read output.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-015 IDLE: if req is non-zero, pick a winner and latch its we, id and wdata; otherwise remain in IDLE.
REQ-016 IDLE with a winner whose id != 0: load the st_* registers and go to ISSUE.
REQ-017 IDLE with a winner whose id == 0: go straight to RESP with err=1; storage is never touched.
REQ-018 For a read, st_read_id = id and st_write_id = 0; for a write, st_write_id = id and st_wdata = wdata.
REQ-019 ISSUE: the st_* ids are non-zero for exactly this one cycle and return to 0 at its end.
REQ-020 ISSUE goes to WAIT for a read and to RESP for a write.
REQ-021 WAIT: capture st_rdata into rdata at the end of the cycle, then go to RESP.
REQ-022 RESP: done[winner]=1 for one cycle, then go to IDLE; the next request is sampled no earlier than that IDLE cycle.
REQ-023 Latency from req sampled (cycle 0): read done in cycle 3, write done in cycle 2, id-0 reject done in cycle 1.
REQ-024 Only one operation is ever outstanding; the winner's st_* ids are never both non-zero.
REQ-025 If req[winner] drops mid-operation, the operation still completes and done still pulses.
REQ-026 Requests that lose arbitration SHALL wait; they receive no done pulse and no err.
REQ-027 rdata is unchanged by write completions and by reject completions.

Reset
REQ-028 A synchronous sys_rst SHALL force state IDLE and clear done, err, busy, st_read_id, st_write_id, st_wdata and rdata to 0.
REQ-029 sys_rst SHALL reset the round-robin pointer to 0.
REQ-030 sys_rst mid-operation SHALL abandon the operation with no done pulse; the st_* ids read 0 in the first cycle after reset.
REQ-031 sys_rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-032 With CHART_ARB_RR_EN defined, arbitration SHALL be round-robin.
REQ-033 Round-robin search starts at the pointer and proceeds pointer, pointer+1, pointer+2 (mod 3).
REQ-034 After each grant, including a reject, the pointer SHALL become winner+1 mod 3.
REQ-035 Without CHART_ARB_RR_EN, arbitration SHALL be fixed priority (requester 0 > 1 > 2) and no pointer exists.

Verification
REQ-036 Read: req=001, we=000, id0=2 -> st_read_id=2 in cycle 1; rdata=st_rdata in cycle 3 with done=001, err=0.
REQ-037 Write: req=010, we=010, id1=3 -> st_write_id=3 and st_wdata=wdata1 for exactly cycle 1; done=010 in cycle 2; st ids 0 otherwise.
REQ-038 Invalid id: req=100, id2=0 -> done=100 with err=1 in cycle 1; st ids stay 0; rdata unchanged.
REQ-039 Contention: req=111 held with CHART_ARB_RR_EN -> done order 001, 010, 100, 001; without the macro -> done order 001, 001, 001.
REQ-040 Reset mid-read: sys_rst asserted during WAIT -> no done pulse; all outputs 0 the next cycle; a new req=010 read completes in 3 cycles.
REQ-041 Dropped request: req0 deasserted during ISSUE -> done=001 is still pulsed in cycle 3.
